// File: rtl/parity_stream_checker.sv
// Streaming multi-lane parity accumulator/checker: folds per-lane parity over a
// last-flagged packet and presents one registered, back-pressurable result per packet.
module parity_stream_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int ODD        = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  in_check,
  input  logic [LANES-1:0]      in_exp_parity,
  output logic [LANES-1:0]      out_parity,
  output logic                  out_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int LW = DATA_WIDTH / LANES;
  localparam logic [LANES-1:0] ODD_MASK = (ODD != 0) ? {LANES{1'b1}} : {LANES{1'b0}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state_q, state_d;
  logic [LANES-1:0]      acc_q, acc_d;
  logic [LANES-1:0]      out_parity_q, out_parity_d;
  logic                  out_error_q, out_error_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

  logic [LANES-1:0]      lane_par;
  logic [LANES-1:0]      acc_n;
  logic                  accept;
  logic                  emit;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_par[gi] = ^in_data[gi*LW +: LW];
  end

  // A pending result only blocks input if it is not being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_n    = acc_q ^ lane_par;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    out_parity_d = out_parity_q;
    out_error_d  = out_error_q;
    out_valid_d  = out_valid_q;
    pkt_count_d  = pkt_count_q;
    err_count_d  = err_count_q;
    emit         = 1'b0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            emit    = 1'b1;
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d   = acc_n;
            state_d = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      out_valid_d  = 1'b1;
      out_parity_d = acc_n ^ ODD_MASK;
      out_error_d  = in_check && (out_parity_d != in_exp_parity);
      pkt_count_d  = pkt_count_q + 1'b1;
      if (out_error_d && (err_count_q != {CNT_WIDTH{1'b1}})) begin
        err_count_d = err_count_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      out_parity_q <= '0;
      out_error_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      out_parity_q <= out_parity_d;
      out_error_q  <= out_error_d;
      out_valid_q  <= out_valid_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_parity = out_parity_q;
  assign out_error  = out_error_q;
  assign out_valid  = out_valid_q;
  assign pkt_count  = pkt_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench: two checker instances (2-lane even with a 3-bit counter, 1-lane odd)
// share one stimulus stream; a reference model pushes expected results, a monitor pops them.
module tb_parity_stream_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_check = 1'b0;
  logic [1:0] in_exp = '0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_error_a, out_valid_a;
  logic [1:0] out_parity_a;
  logic [2:0] pkt_count_a, err_count_a;

  logic        in_ready_b, out_error_b, out_valid_b;
  logic [0:0]  out_parity_b;
  logic [15:0] pkt_count_b, err_count_b;

  parity_stream_checker #(.DATA_WIDTH(8), .LANES(2), .ODD(0), .CNT_WIDTH(3)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_last(in_last), .in_check(in_check), .in_exp_parity(in_exp),
    .out_parity(out_parity_a), .out_error(out_error_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .pkt_count(pkt_count_a), .err_count(err_count_a)
  );

  parity_stream_checker #(.DATA_WIDTH(8), .LANES(1), .ODD(1), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .in_check(in_check), .in_exp_parity(in_exp[0:0]),
    .out_parity(out_parity_b), .out_error(out_error_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .pkt_count(pkt_count_b), .err_count(err_count_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pa;
    int ea;
    int pb;
    int eb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  // reference state: packet parity as bit counts, output occupancy, counters
  int ones_lo, ones_hi, ones_all;
  bit exp_valid = 0;
  int m_pkt_a = 0, m_err_a = 0, m_pkt_b = 0, m_err_b = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) #1 begin
    if (ready_mode == 0)      out_ready = 1'b0;
    else if (ready_mode == 1) out_ready = 1'b1;
    else                      out_ready = 1'($urandom_range(0, 1));
  end

  // Reference model: evaluated on the same edge the DUT samples.
  always @(posedge clk) begin
    bit   emit;
    bit   rdy;
    exp_t e;
    emit = 0;
    if (rst) begin
      ones_lo = 0; ones_hi = 0; ones_all = 0;
      exp_valid = 0;
      m_pkt_a = 0; m_err_a = 0; m_pkt_b = 0; m_err_b = 0;
      q.delete();
    end else begin
      rdy = !exp_valid || out_ready;
      if (in_valid && rdy) begin
        ones_lo  += $countones(in_data[3:0]);
        ones_hi  += $countones(in_data[7:4]);
        ones_all += $countones(in_data);
        if (in_last) begin
          e.pa = (ones_lo % 2) + 2 * (ones_hi % 2);
          e.pb = 1 - (ones_all % 2);
          e.ea = (in_check && e.pa != int'(in_exp)) ? 1 : 0;
          e.eb = (in_check && e.pb != int'(in_exp[0])) ? 1 : 0;
          q.push_back(e);
          m_pkt_a = (m_pkt_a + 1) % 8;
          m_pkt_b = (m_pkt_b + 1) % 65536;
          if (e.ea == 1 && m_err_a < 7) m_err_a++;
          if (e.eb == 1) m_err_b++;
          ones_lo = 0; ones_hi = 0; ones_all = 0;
          emit = 1;
        end
      end
      if (emit)           exp_valid = 1;
      else if (out_ready) exp_valid = 0;
    end
  end

  // Monitor: compares the presented result against the queue head, pops on consume.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("in_ready_a", int'(in_ready_a), int'(!exp_valid || out_ready));
      chk("in_ready_b", int'(in_ready_b), int'(!exp_valid || out_ready));
      chk("out_valid_a", int'(out_valid_a), int'(exp_valid));
      chk("out_valid_b", int'(out_valid_b), int'(exp_valid));
      chk("pkt_count_a", int'(pkt_count_a), m_pkt_a);
      chk("err_count_a", int'(err_count_a), m_err_a);
      chk("pkt_count_b", int'(pkt_count_b), m_pkt_b);
      chk("err_count_b", int'(err_count_b), m_err_b);
      if (out_valid_a) begin
        if (q.size() == 0) begin
          chk("result_expected", 0, 1);
        end else begin
          chk("out_parity_a", int'(out_parity_a), q[0].pa);
          chk("out_error_a", int'(out_error_a), q[0].ea);
          chk("out_parity_b", int'(out_parity_b), q[0].pb);
          chk("out_error_b", int'(out_error_b), q[0].eb);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit check, input logic [1:0] ex);
    bit ok;
    int waited;
    in_data = d; in_last = last; in_check = check; in_exp = ex; in_valid = 1'b1;
    ok = 0;
    waited = 0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = in_ready_a;
      step();
      waited++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    $display("beat data=%02h last=%0b check=%0b exp=%0d", d, last, check, ex);
    in_valid = 1'b0;
    in_data = $urandom();
    in_last = 1'($urandom_range(0, 1));
    in_check = 1'($urandom_range(0, 1));
    in_exp = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int len, waited;
    do_reset();
    started = 1;
    step();
    ready_mode = 1;

    send(8'h07, 1, 0, 2'd0);
    send(8'h01, 0, 0, 2'd0);
    step();
    send(8'h02, 1, 0, 2'd0);
    send(8'h31, 1, 0, 2'd0);
    send(8'h00, 1, 0, 2'd0);
    send(8'h03, 1, 1, 2'd1);
    step();

    // stall: A waits for out_ready while B's last beat is presented
    ready_mode = 0;
    step();
    send(8'h5A, 1, 1, 2'd3);
    fork
      send(8'hC4, 1, 1, 2'd2);
      begin
        repeat (5) step();
        ready_mode = 1;
      end
    join
    repeat (3) step();

    // abandoned packet then reset
    send(8'h01, 0, 0, 2'd0);
    do_reset();
    send(8'h02, 1, 0, 2'd0);

    // back-to-back single-beat stream, mostly mismatching to saturate err_count_a
    for (int i = 0; i < 12; i++) send(8'($urandom()), 1, 1, 2'($urandom_range(0, 3)));

    ready_mode = 2;
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send(8'($urandom()), b == len - 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end
      if (p % 40 == 39) ready_mode = (ready_mode == 2) ? 1 : 2;
    end

    ready_mode = 1;
    waited = 0;
    while ((q.size() != 0 || out_valid_a) && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) chk("drain_timeout", 0, 1);
    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
